// File: rtl/gpio_port.sv
// Memory-mapped GPIO for the iceMCU 6502 bus: per-pin direction, synchronised
// inputs and per-pin edge interrupts with selectable polarity.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_OUT   = 3'd0,
    REG_DIR   = 3'd1,
    REG_IN    = 3'd2,
    REG_IEN   = 3'd3,
    REG_IPOL  = 3'd4,
    REG_ISTAT = 3'd5
  } reg_sel_e;

  localparam int CNT_W = 3;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] ipol_q, ipol_d;
  logic [WIDTH-1:0] istat_q, istat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dout_q, dout_d;

  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c;
  logic [2:0]       reg_sel;

  // Replace one byte lane of a register; lanes beyond WIDTH fall off the top.
  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] cur,
                                                  input logic hi,
                                                  input logic [7:0] data);
    logic [15:0] ext;
    ext = 16'(cur);
    if (hi) ext[15:8] = data;
    else    ext[7:0]  = data;
    return ext[WIDTH-1:0];
  endfunction

  function automatic logic [7:0] lane_read(input logic [WIDTH-1:0] v, input logic hi);
    logic [15:0] ext;
    ext = 16'(v);
    return hi ? ext[15:8] : ext[7:0];
  endfunction

  always_comb begin
    in_w    = sync_q[SYNC_STAGES-1];
    reg_sel = addr[3:1];

    sync_d[0] = gpio_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = in_w;

    // Edges are ignored until the chain and prev hold real pin history.
    cnt_d    = primed_q ? cnt_q : cnt_q + CNT_W'(1);
    primed_d = primed_q | (cnt_q == CNT_W'(SYNC_STAGES));
    edge_hit = primed_q ? ((~ipol_q & in_w & ~prev_q) | (ipol_q & ~in_w & prev_q)) : '0;

    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    ipol_d = ipol_q;
    w1c    = '0;
    if (cs && we) begin
      case (reg_sel)
        REG_OUT:   out_d  = lane_merge(out_q, addr[0], din);
        REG_DIR:   dir_d  = lane_merge(dir_q, addr[0], din);
        REG_IEN:   ien_d  = lane_merge(ien_q, addr[0], din);
        REG_IPOL:  ipol_d = lane_merge(ipol_q, addr[0], din);
        REG_ISTAT: w1c    = lane_merge('0, addr[0], din);
        default:   ;
      endcase
    end
    istat_d = (istat_q & ~w1c) | edge_hit;

    dout_d = dout_q;
    if (cs && !we) begin
      case (reg_sel)
        REG_OUT:   dout_d = lane_read(out_q, addr[0]);
        REG_DIR:   dout_d = lane_read(dir_q, addr[0]);
        REG_IN:    dout_d = lane_read(in_w, addr[0]);
        REG_IEN:   dout_d = lane_read(ien_q, addr[0]);
        REG_IPOL:  dout_d = lane_read(ipol_q, addr[0]);
        REG_ISTAT: dout_d = lane_read(istat_q, addr[0]);
        default:   dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      ipol_q   <= '0;
      istat_q  <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      ipol_q   <= ipol_d;
      istat_q  <= istat_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign dout    = dout_q;
  assign irq     = |(istat_q & ien_q);

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO peripheral for the iceMCU 6502 system bus, replacing the fixed 8-bit in/out ports. It provides per-pin direction control, a metastability-hardened input path, and per-pin edge-detect interrupts with selectable polarity. It sits on the CPU data bus beside the UART and RAM, selected by the address decoder, and drives a level `irq` into the CPU interrupt line.

## Interface
Parameters:
- `WIDTH`, 8: number of pins, 1..16.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `cs` input 1: peripheral select from the address decoder.
- `we` input 1: 1 = write, 0 = read (valid when `cs`=1).
- `addr` input 4: register address; `addr[3:1]` selects the register, `addr[0]` selects the byte (0 = bits 7:0, 1 = bits 15:8).
- `din` input 8: write data.
- `dout` output 8: registered read data.
- `gpio_i` input WIDTH: asynchronous pin inputs.
- `gpio_o` output WIDTH: pin output values.
- `gpio_oe` output WIDTH: pin output enables (1 = drive).
- `irq` output 1: interrupt request, active-high level.

## Operation
- Register map, by `addr[3:1]`:
  - 0 `OUT`: RW.
  - 1 `DIR`: RW; 1 = output.
  - 2 `IN`: RO; synchronised pin state.
  - 3 `IEN`: RW; interrupt enable per pin.
  - 4 `IPOL`: RW; 0 = rising edge, 1 = falling edge.
  - 5 `ISTAT`: R; write-1-to-clear.
  - 6, 7: reserved; read 0, writes ignored.
- Bits at or above WIDTH read 0 and ignore writes. High byte (`addr[0]`=1) reads 0 when WIDTH ≤ 8.
- A write occurs on any cycle with `cs`=1 and `we`=1. It updates only the addressed byte lane.
- `gpio_o` = `OUT`; `gpio_oe` = `DIR`. `OUT` is held regardless of `DIR`.
- Input path: `gpio_i` passes through a SYNC_STAGES flop chain into `IN`. `prev` holds `IN` delayed one cycle.
- Edge detect, per pin *i*: `IPOL[i]`=0 detects `IN[i]` & ~`prev[i]`; `IPOL[i]`=1 detects ~`IN[i]` & `prev[i]`.
- A detected edge sets `ISTAT[i]` whether or not `IEN[i]` is set, so the status can be polled.
- `irq` = OR over (`ISTAT` & `IEN`), decoded combinationally from registers.
- `ISTAT` write: 1 bits clear, 0 bits leave unchanged. If an edge and a W1C hit the same bit in the same cycle, set wins (the bit stays 1).
- Writing `IPOL` does not create an edge and does not change `ISTAT`.
- Arming: a `primed` flag is 0 after reset and sets after SYNC_STAGES+1 cycles, counted by an internal counter. Edge detect is suppressed while `primed`=0, so pins held high through reset cause no spurious status.
- Reset (synchronous, any cycle, including mid-transaction) clears:
  - `OUT`, `DIR`, `IEN`, `IPOL`, `ISTAT`, the synchroniser chain, `prev`, `primed`, the counter and `dout`.
  - Consequence: all outputs are 0 after reset, and `irq`=0.

## Timing
- Read: `cs`=1, `we`=0 at cycle N → `dout` valid from cycle N+1, matching the 6502 core's registered data-in. `dout` holds its last value when not reading.
- Reading `ISTAT` has no side effects.
- Write: register updated at the clock edge ending cycle N. `gpio_o`/`gpio_oe` change in cycle N+1.
- Input latency: a `gpio_i` change stable before edge E appears in `IN` after SYNC_STAGES edges. `ISTAT`/`irq` assert one edge later (SYNC_STAGES+1 total).
- Read-after-write to the same register on consecutive cycles returns the new value.
- Pulses shorter than one clock period may be missed. This is not required to be detected.

## Test plan
- Reset with `gpio_i`=16'hFFFF, WIDTH=8 → all outputs 0; `IN` reads 8'hFF after SYNC_STAGES+1 cycles; `ISTAT`=0; `irq`=0.
- Write `OUT`=8'hA5 then `DIR`=8'h0F → `gpio_o`=8'hA5 and `gpio_oe`=8'h0F on the cycle after each write. Readback returns `dout`=A5 then 0F one cycle after each read.
- WIDTH=12: write 8'hFF to `OUT` high byte → reads 8'h0F and `gpio_o[11:8]`=4'hF. Reads of reg 6 and 7 return 0.
- `IEN`=8'h01, `IPOL`=0; pulse `gpio_i[0]` 0→1 → `ISTAT`=8'h01 and `irq`=1 exactly SYNC_STAGES+1 cycles after the change. Write `ISTAT`=8'h01 → `irq`=0 the next cycle.
- `IPOL`=8'h02 (falling) with `IEN[1]`=0; drive `gpio_i[1]` 1→0 → `ISTAT[1]`=1 and `irq` stays 0. Set `IEN[1]`=1 → `irq`=1 the next cycle.
- W1C write to `ISTAT[0]` on the same cycle an edge is detected on pin 0 → `ISTAT[0]` stays 1. Assert `reset` mid-sequence → all registers and `irq` are 0 on the next cycle.
